// File: rtl/somador_serial_ctrl.sv
// Bit-serial adder: {cout, soma} = a + b + cin, LSB first, one bit per clock.
// Ports: clk, rst (async, high), start/a/b/cin in; busy, done, soma, cout out.

module SomadorCompleto1Bit (
  input  logic x,
  input  logic y,
  input  logic Cin,
  output logic A,
  output logic Cout
);

  assign A    = x ^ y ^ Cin;
  assign Cout = (x & y) | (x & Cin) | (y & Cin);

endmodule

module somador_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] soma,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             carry_nx;
  logic             last;
  logic [WIDTH-1:0] sr_nx;

  SomadorCompleto1Bit u_fa (
    .x    (sa[0]),
    .y    (sb[0]),
    .Cin  (carry),
    .A    (sum_bit),
    .Cout (carry_nx)
  );

  assign last  = (cnt == LAST);
  assign sr_nx = {sum_bit, sr[WIDTH-1:1]};

  always_comb begin
    state_nx = IDLE;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        state_nx = start ? SHIFT : IDLE;
      end
      SHIFT: begin
        busy     = 1'b1;
        state_nx = last ? DONE : SHIFT;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Datapath. soma/cout only update on the final shift edge so they
  // hold the previous result for the whole of the next operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      soma  <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            sr    <= '0;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sr    <= sr_nx;
          carry <= carry_nx;
          cnt   <= cnt + 1'b1;
          if (last) begin
            soma <= sr_nx;
            cout <= carry_nx;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_somador_serial_ctrl.sv
// Directed self-checking bench for somador_serial_ctrl, WIDTH=8.
// Ports driven: clk, rst, start, a, b, cin; observed: busy, done, soma, cout.

module tb_somador_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] soma;
  logic       cout;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  somador_serial_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .soma  (soma),
    .cout  (cout)
  );

  // Runs one operation from IDLE; returns result, edges from accept to
  // done (accept edge counted) and cycles busy was seen high.
  task automatic run_op(
    input  logic [7:0] ia,
    input  logic [7:0] ib,
    input  logic       ic,
    output logic [8:0] res,
    output int         edges,
    output int         bcnt,
    output bit         tmo
  );
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    bcnt = busy ? 1 : 0;
    tmo = 1'b1;
    res = '0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      edges++;
      if (busy) bcnt++;
      if (done) begin
        res = {cout, soma};
        tmo = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (busy !== 1'b0) begin
      nerr++; $display("FAIL reset_busy got %b want 0", busy);
    end
    nvec++;
    if (done !== 1'b0) begin
      nerr++; $display("FAIL reset_done got %b want 0", done);
    end
    nvec++;
    if (soma !== 8'h00) begin
      nerr++; $display("FAIL reset_soma got %h want 00", soma);
    end
    nvec++;
    if (cout !== 1'b0) begin
      nerr++; $display("FAIL reset_cout got %b want 0", cout);
    end
    start = 1'b0;
    #4 rst = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (busy !== 1'b0) begin
      nerr++; $display("FAIL post_reset_idle busy got %b want 0", busy);
    end
  endtask

  task automatic test_basic;
    logic [8:0] r;
    int e, bc;
    bit t;
    run_op(8'h3C, 8'h5A, 1'b0, r, e, bc, t);
    nvec++;
    if (t || r !== 9'h096) begin
      nerr++; $display("FAIL basic_sum got %h tmo=%0d want 096", r, t);
    end
    nvec++;
    if (e !== 9) begin
      nerr++; $display("FAIL basic_latency got %0d want 9", e);
    end
    nvec++;
    if (bc !== 9) begin
      nerr++; $display("FAIL basic_busy_cycles got %0d want 9", bc);
    end
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL basic_back_idle busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_overflow;
    logic [8:0] r;
    int e, bc;
    bit t;
    run_op(8'hFF, 8'h01, 1'b0, r, e, bc, t);
    nvec++;
    if (t || r !== 9'h100) begin
      nerr++; $display("FAIL ovf_ff_01 got %h want 100", r);
    end
    run_op(8'hFF, 8'hFF, 1'b1, r, e, bc, t);
    nvec++;
    if (t || r !== 9'h1FF) begin
      nerr++; $display("FAIL ovf_ff_ff_1 got %h want 1ff", r);
    end
  endtask

  // Previous result is 0x1FF; it must hold through SHIFT.
  task automatic test_ignore_start;
    int ndone = 0;
    bit held = 1'b1;
    logic [8:0] r = '0;
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'hAA;
    for (int c = 1; c < 30; c++) begin
      if (c == 3) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (busy && !done && {cout, soma} !== 9'h1FF) held = 1'b0;
      if (done) begin
        ndone++;
        r = {cout, soma};
      end
    end
    nvec++;
    if (ndone !== 1) begin
      nerr++; $display("FAIL ign_done_count got %0d want 1", ndone);
    end
    nvec++;
    if (r !== 9'h010) begin
      nerr++; $display("FAIL ign_result got %h want 010", r);
    end
    nvec++;
    if (!held) begin
      nerr++; $display("FAIL ign_soma_hold changed during shift want 1ff");
    end
  endtask

  task automatic test_reset_midop;
    int ndone = 0;
    logic [8:0] r;
    int e, bc;
    bit t;
    a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++; $display("FAIL midrst_ctrl busy=%b done=%b want 0 0", busy, done);
    end
    nvec++;
    if ({cout, soma} !== 9'h000) begin
      nerr++; $display("FAIL midrst_result got %h want 000", {cout, soma});
    end
    #2 rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    nvec++;
    if (ndone !== 0) begin
      nerr++; $display("FAIL midrst_no_done got %0d want 0", ndone);
    end
    run_op(8'h01, 8'h02, 1'b0, r, e, bc, t);
    nvec++;
    if (t || r !== 9'h003) begin
      nerr++; $display("FAIL midrst_fresh got %h want 003", r);
    end
  endtask

  task automatic test_back_to_back;
    int tm[3];
    int nd = 0;
    bit ok = 1'b1;
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (c == 24) start = 1'b0;
      if (done) begin
        if (nd < 3) tm[nd] = c;
        nd++;
        if ({cout, soma} !== 9'h002) ok = 1'b0;
      end
    end
    nvec++;
    if (nd !== 3) begin
      nerr++; $display("FAIL b2b_count got %0d want 3", nd);
    end else begin
      nvec++;
      if (tm[1] - tm[0] !== 10 || tm[2] - tm[1] !== 10) begin
        nerr++;
        $display("FAIL b2b_spacing got %0d %0d want 10 10",
                 tm[1] - tm[0], tm[2] - tm[1]);
      end
    end
    nvec++;
    if (!ok) begin
      nerr++; $display("FAIL b2b_result got non-002 result want 002");
    end
  endtask

  task automatic test_sweep;
    logic [7:0] v[8] = '{8'h00, 8'h01, 8'h55, 8'h7F,
                         8'h80, 8'hAA, 8'hFE, 8'hFF};
    logic [8:0] r, exp;
    int e, bc;
    bit t;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        for (int k = 0; k < 2; k++) begin
          exp = {1'b0, v[i]} + {1'b0, v[j]} + 9'(k);
          run_op(v[i], v[j], k[0], r, e, bc, t);
          nvec++;
          if (t || r !== exp || e !== 9) begin
            nerr++;
            $display("FAIL sweep a=%h b=%h cin=%0d got %h lat %0d want %h lat 9",
                     v[i], v[j], k, r, e, exp);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_ignore_start;
    test_reset_midop;
    test_back_to_back;
    test_sweep;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
